// File: rtl/id_exe_pipe_if.sv
// id_exe_pipe_if: ID-side and EXE-side handshake plus payload of the ID->EXE register.
// Latency: none, wires only.
// Backpressure: carries id_ready (upstream) and exe_ready (downstream).
interface id_exe_pipe_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int RN_W   = 5
);
  logic              id_valid;
  logic              id_ready;
  logic [CTRL_W-1:0] id_ctrl;
  logic [DATA_W-1:0] id_a;
  logic [DATA_W-1:0] id_b;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_pc;
  logic [RN_W-1:0]   id_rn;

  logic              exe_valid;
  logic              exe_ready;
  logic [CTRL_W-1:0] exe_ctrl;
  logic [DATA_W-1:0] exe_a;
  logic [DATA_W-1:0] exe_b;
  logic [DATA_W-1:0] exe_imm;
  logic [DATA_W-1:0] exe_pc;
  logic [RN_W-1:0]   exe_rn;

  // The pipe register itself: consumes ID beats, produces EXE beats.
  modport slave (
    input  id_valid, id_ctrl, id_a, id_b, id_imm, id_pc, id_rn, exe_ready,
    output id_ready, exe_valid, exe_ctrl, exe_a, exe_b, exe_imm, exe_pc, exe_rn
  );

  // The surrounding pipeline: drives ID beats and the EXE consume strobe.
  modport master (
    output id_valid, id_ctrl, id_a, id_b, id_imm, id_pc, id_rn, exe_ready,
    input  id_ready, exe_valid, exe_ctrl, exe_a, exe_b, exe_imm, exe_pc, exe_rn
  );
endinterface

// File: rtl/id_exe_pipe.sv
// id_exe_pipe: ID->EXE pipeline register, optional skid entry under macro ID_EXE_SKID_BUF_EN.
// Latency: one cycle from accept to exe_* outputs.
// Backpressure: exe_ready low holds main; with skid, id_ready is registered (!skid_valid), else !exe_valid || exe_ready.
module id_exe_pipe #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int RN_W   = 5
) (
  input  logic         clk,
  input  logic         clrn,
  id_exe_pipe_if.slave bus,
  input  logic         flush,
  output logic [15:0]  bubble_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [RN_W-1:0]   rn;
  } beat_t;

  beat_t       w_in_beat;
  beat_t       w_src;
  logic        w_src_vld;
  logic        w_id_rdy;
  logic        w_accept;
  logic        w_main_free;

  logic        r_main_vld;
  beat_t       r_main;
  logic [15:0] r_bubble;

  assign w_in_beat   = {bus.id_ctrl, bus.id_a, bus.id_b, bus.id_imm, bus.id_pc, bus.id_rn};
  assign w_accept    = bus.id_valid && w_id_rdy;
  // Main may take a new beat when it is empty or its current beat leaves this edge.
  assign w_main_free = !r_main_vld || bus.exe_ready;
  assign bus.id_ready = w_id_rdy;

`ifdef ID_EXE_SKID_BUF_EN
  logic  r_skid_vld;
  beat_t r_skid;
  logic  r_id_rdy;
  logic  w_skid_vld_nxt;

  assign w_id_rdy  = r_id_rdy;
  // Skid beat is older than any input beat, so it always wins the main slot.
  assign w_src_vld = r_skid_vld || w_accept;
  assign w_src     = r_skid_vld ? r_skid : w_in_beat;

  // Next skid occupancy: drains when main frees, fills on an accept main cannot take.
  always_comb begin
    w_skid_vld_nxt = r_skid_vld;
    if (flush) begin
      w_skid_vld_nxt = 1'b0;
    end else if (r_skid_vld && w_main_free) begin
      w_skid_vld_nxt = 1'b0;
    end else if (w_accept && !w_main_free) begin
      w_skid_vld_nxt = 1'b1;
    end
  end

  // Skid storage; id_ready registered from next occupancy so it never sees exe_ready combinationally.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_skid_vld <= 1'b0;
      r_id_rdy   <= 1'b1;
      r_skid     <= '0;
    end else begin
      r_skid_vld <= w_skid_vld_nxt;
      r_id_rdy   <= !w_skid_vld_nxt;
      // Accept is only possible while the skid is empty, so a valid skid is never overwritten.
      if (!flush && w_accept && !w_main_free) begin
        r_skid <= w_in_beat;
      end
    end
  end
`else
  assign w_id_rdy  = w_main_free;
  assign w_src_vld = w_accept;
  assign w_src     = w_in_beat;
`endif

  // Main entry: flush only drops valid, payload keeps its last value.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_main_vld <= 1'b0;
      r_main     <= '0;
    end else if (flush) begin
      r_main_vld <= 1'b0;
    end else if (w_main_free) begin
      r_main_vld <= w_src_vld;
      if (w_src_vld) begin
        r_main <= w_src;
      end
    end
  end

  // Saturating count of edges where EXE sees no valid beat.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_bubble <= 16'd0;
    end else if (!r_main_vld && (r_bubble != 16'hFFFF)) begin
      r_bubble <= r_bubble + 16'd1;
    end
  end

  assign bus.exe_valid = r_main_vld;
  assign {bus.exe_ctrl, bus.exe_a, bus.exe_b, bus.exe_imm, bus.exe_pc, bus.exe_rn} = r_main;
  assign bubble_cnt = r_bubble;

endmodule

// File: tb/tb_id_exe_pipe.sv
// tb_id_exe_pipe: directed scenarios plus randomized traffic against a FIFO-level reference model.
// Latency: model treats the stage as a queue of depth 2 (skid) or 1 (no skid).
// Backpressure: exe_ready randomized; model derives id_ready from queue occupancy.
module tb_id_exe_pipe;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int RW = 5;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
    logic [RW-1:0] rn;
  } beat_t;

  logic        clk;
  logic        clrn;
  logic        flush;
  logic [15:0] bubble_cnt;

  id_exe_pipe_if #(.DATA_W(DW), .CTRL_W(CW), .RN_W(RW)) bus ();

  id_exe_pipe #(.DATA_W(DW), .CTRL_W(CW), .RN_W(RW)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .bus        (bus),
    .flush      (flush),
    .bubble_cnt (bubble_cnt)
  );

  beat_t mq[$];
  int    mbub;
  int    n_tests;
  int    n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  function automatic bit m_id_ready();
`ifdef ID_EXE_SKID_BUF_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || bus.exe_ready;
`endif
  endfunction

  function automatic beat_t in_beat();
    return {bus.id_ctrl, bus.id_a, bus.id_b, bus.id_imm, bus.id_pc, bus.id_rn};
  endfunction

  function automatic beat_t dut_beat();
    return {bus.exe_ctrl, bus.exe_a, bus.exe_b, bus.exe_imm, bus.exe_pc, bus.exe_rn};
  endfunction

  task automatic drive(input bit v, input logic [DW-1:0] pc);
    bus.id_valid = v;
    bus.id_ctrl  = CW'($urandom);
    bus.id_a     = $urandom;
    bus.id_b     = $urandom;
    bus.id_imm   = $urandom;
    bus.id_pc    = pc;
    bus.id_rn    = RW'($urandom);
  endtask

  // Reference model for one rising edge: bubbles counted on the pre-edge state, flush empties the queue.
  task automatic model_edge();
    bit acc;
    bit xfr;
    acc = bus.id_valid && m_id_ready();
    xfr = (mq.size() > 0) && bus.exe_ready;
    if (mq.size() == 0 && mbub < 65535) mbub++;
    if (flush) begin
      mq.delete();
    end else begin
      if (xfr) void'(mq.pop_front());
      if (acc) mq.push_back(in_beat());
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 clrn = 1'b0;
    #1;
    n_tests++; if (bus.exe_valid !== 1'b0) begin n_fail++; $display("FAIL reset_exe_valid: got %b want 0", bus.exe_valid); end
    n_tests++; if (dut_beat() !== '0) begin n_fail++; $display("FAIL reset_payload: got %h want 0", dut_beat()); end
    n_tests++; if (bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_bubble: got %0d want 0", bubble_cnt); end
    n_tests++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL reset_id_ready: got %b want 1", bus.id_ready); end
    @(negedge clk);
    clrn = 1'b1;
    model_edge();
    @(posedge clk);
    #1;
    n_tests++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL release_id_ready: got %b want 1", bus.id_ready); end
    n_tests++; if (bubble_cnt !== 16'd1) begin n_fail++; $display("FAIL release_bubble: got %0d want 1", bubble_cnt); end
  endtask

  task automatic test_stream();
    logic [DW-1:0] pcs[3];
    pcs[0] = 32'h00; pcs[1] = 32'h04; pcs[2] = 32'h08;
    bus.exe_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i]);
      tick();
      n_tests++; if (bus.exe_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", i, bus.exe_valid); end
      n_tests++; if (bus.exe_pc !== pcs[i]) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", i, bus.exe_pc, pcs[i]); end
    end
    drive(1'b0, 32'h0);
    tick();
    n_tests++; if (bus.exe_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b want 0", bus.exe_valid); end
  endtask

`ifdef ID_EXE_SKID_BUF_EN
  task automatic test_stall();
    bus.exe_ready = 1'b0;
    drive(1'b1, 32'h10);
    tick();
    drive(1'b1, 32'h14);
    #1;
    n_tests++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL stall_rdy_before: got %b want 1", bus.id_ready); end
    tick();
    drive(1'b0, 32'h0);
    #1;
    n_tests++; if (bus.id_ready !== 1'b0) begin n_fail++; $display("FAIL stall_rdy_full: got %b want 0", bus.id_ready); end
    n_tests++; if (bus.exe_pc !== 32'h10) begin n_fail++; $display("FAIL stall_hold_pc: got %h want 10", bus.exe_pc); end
    tick();
    n_tests++; if (bus.exe_pc !== 32'h10) begin n_fail++; $display("FAIL stall_stable_pc: got %h want 10", bus.exe_pc); end
    bus.exe_ready = 1'b1;
    tick();
    n_tests++; if (bus.exe_pc !== 32'h14) begin n_fail++; $display("FAIL stall_skid_pc: got %h want 14", bus.exe_pc); end
    n_tests++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL stall_rdy_after: got %b want 1", bus.id_ready); end
    tick();
    n_tests++; if (bus.exe_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b want 0", bus.exe_valid); end
  endtask
`else
  task automatic test_stall();
    bus.exe_ready = 1'b0;
    drive(1'b1, 32'h10);
    tick();
    drive(1'b1, 32'h14);
    #1;
    n_tests++; if (bus.id_ready !== 1'b0) begin n_fail++; $display("FAIL stall_rdy_comb_low: got %b want 0", bus.id_ready); end
    bus.exe_ready = 1'b1;
    #1;
    n_tests++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL stall_rdy_comb_high: got %b want 1", bus.id_ready); end
    tick();
    n_tests++; if (bus.exe_pc !== 32'h14) begin n_fail++; $display("FAIL stall_next_pc: got %h want 14", bus.exe_pc); end
    n_tests++; if (bus.exe_valid !== 1'b1) begin n_fail++; $display("FAIL stall_next_valid: got %b want 1", bus.exe_valid); end
    drive(1'b0, 32'h0);
    tick();
    n_tests++; if (bus.exe_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b want 0", bus.exe_valid); end
  endtask
`endif

  task automatic test_flush();
    bus.exe_ready = 1'b0;
    drive(1'b1, 32'h20);
    tick();
    drive(1'b1, 32'h24);
    tick();
    drive(1'b1, 32'h28);
    flush = 1'b1;
    bus.exe_ready = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    #1;
    n_tests++; if (bus.exe_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", bus.exe_valid); end
    n_tests++; if (bus.exe_pc !== 32'h20) begin n_fail++; $display("FAIL flush_payload_held: got %h want 20", bus.exe_pc); end
    n_tests++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL flush_id_ready: got %b want 1", bus.id_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (bus.exe_valid !== 1'b0 || bus.exe_pc === 32'h28) begin
        n_fail++; $display("FAIL flush_after[%0d]: got valid %b pc %h want valid 0 and pc not 28", i, bus.exe_valid, bus.exe_pc);
      end
    end
  endtask

  task automatic test_reset_midstall();
    bus.exe_ready = 1'b0;
    drive(1'b1, 32'h30);
    tick();
    drive(1'b1, 32'h34);
    tick();
    drive(1'b0, 32'h0);
    n_tests++; if (bus.exe_valid !== 1'b1) begin n_fail++; $display("FAIL midstall_pre_valid: got %b want 1", bus.exe_valid); end
    clrn = 1'b0;
    #2;
    n_tests++; if (bus.exe_valid !== 1'b0) begin n_fail++; $display("FAIL midstall_valid: got %b want 0", bus.exe_valid); end
    n_tests++; if (bus.exe_a !== '0) begin n_fail++; $display("FAIL midstall_exe_a: got %h want 0", bus.exe_a); end
    n_tests++; if (bus.exe_pc !== '0) begin n_fail++; $display("FAIL midstall_exe_pc: got %h want 0", bus.exe_pc); end
    n_tests++; if (bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL midstall_bubble: got %0d want 0", bubble_cnt); end
    mq.delete();
    mbub = 0;
    @(negedge clk);
    clrn = 1'b1;
    bus.exe_ready = 1'b1;
    model_edge();
    @(posedge clk);
    #1;
    n_tests++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL midstall_rdy: got %b want 1", bus.id_ready); end
    n_tests++; if (bus.exe_valid !== 1'b0) begin n_fail++; $display("FAIL midstall_discard: got %b want 0", bus.exe_valid); end
    n_tests++; if (bubble_cnt !== 16'd1) begin n_fail++; $display("FAIL midstall_bubble_after: got %0d want 1", bubble_cnt); end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom);
      bus.exe_ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 19) == 0;
      #1;
      n_tests++; if (bus.exe_valid !== 1'(mq.size() > 0)) begin
        n_fail++; $display("FAIL random_valid[%0d]: got %b want %b", i, bus.exe_valid, mq.size() > 0);
      end
      if (mq.size() > 0) begin
        n_tests++; if (dut_beat() !== mq[0]) begin
          n_fail++; $display("FAIL random_payload[%0d]: got %h want %h", i, dut_beat(), mq[0]);
        end
      end
      n_tests++; if (bus.id_ready !== m_id_ready()) begin
        n_fail++; $display("FAIL random_id_ready[%0d]: got %b want %b", i, bus.id_ready, m_id_ready());
      end
      n_tests++; if (bubble_cnt !== 16'(mbub)) begin
        n_fail++; $display("FAIL random_bubble[%0d]: got %0d want %0d", i, bubble_cnt, mbub);
      end
      tick();
    end
    flush = 1'b0;
  endtask

  task automatic test_bubble_sat();
    drive(1'b0, 32'h0);
    bus.exe_ready = 1'b1;
    flush = 1'b0;
    repeat (70000) tick();
    n_tests++; if (bubble_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h want FFFF", bubble_cnt); end
    repeat (3) tick();
    n_tests++; if (bubble_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_stay: got %h want FFFF", bubble_cnt); end
    drive(1'b1, 32'h40);
    tick();
    n_tests++; if (bus.exe_valid !== 1'b1 || bus.exe_pc !== 32'h40) begin
      n_fail++; $display("FAIL sat_beat: got valid %b pc %h want valid 1 pc 40", bus.exe_valid, bus.exe_pc);
    end
    n_tests++; if (bubble_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_with_beat: got %h want FFFF", bubble_cnt); end
    drive(1'b0, 32'h0);
    tick();
    n_tests++; if (bubble_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_no_wrap: got %h want FFFF", bubble_cnt); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    mbub    = 0;
    clrn    = 1'b1;
    flush   = 1'b0;
    bus.exe_ready = 1'b0;
    drive(1'b0, 32'h0);
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_reset_midstall();
    test_random(400);
    test_bubble_sat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
